// File: rtl/turbo_encoder_core.sv
// Turbo encoder core: two identical RSC encoders, the second reading the frame
// through a QPP interleaver generated incrementally (compare-subtract only).
// Optional trellis termination is compiled in with `define TURBO_TERM_EN.
module turbo_encoder_core #(
    parameter int unsigned       MEM       = 2,
    parameter logic [MEM-1:0]    FB_POLY   = MEM'(2'b11),
    parameter logic [MEM-1:0]    FF_POLY   = MEM'(2'b10),
    parameter int unsigned       FRAME_MAX = 256,
    localparam int unsigned      LW        = $clog2(FRAME_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_bit,
    input  logic [LW-1:0] cfg_len,
    input  logic [LW-1:0] cfg_f1,
    input  logic [LW-1:0] cfg_f2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sys,
    output logic          out_par1,
    output logic          out_par2,
    output logic          out_tail,
    output logic          out_last,
    output logic [LW-1:0] out_idx,
    output logic          busy
);

    localparam int unsigned    AW   = (FRAME_MAX > 1) ? $clog2(FRAME_MAX) : 1;
    localparam logic [LW-1:0]  NMAX = LW'(FRAME_MAX);
`ifdef TURBO_TERM_EN
    localparam logic [LW-1:0]  TLAST = LW'(MEM - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ENCODE
`ifdef TURBO_TERM_EN
        ,
        TERM1,
        TERM2
`endif
    } state_e;

    // One RSC step: returns {parity, next_state}
    function automatic logic [MEM:0] rsc_step(input logic [MEM-1:0] s, input logic u);
        logic a;
        a = u ^ (^(s & FB_POLY));
        return {a ^ (^(s & FF_POLY)), s[MEM-2:0], a};
    endfunction

    // Reduce x (< 3n when coefficients are in range) into [0, n) by compare-subtract
    function automatic logic [LW-1:0] mod_n(input logic [LW+1:0] x, input logic [LW-1:0] n);
        logic [LW+1:0] r;
        logic [LW+1:0] nn;
        r  = x;
        nn = (LW+2)'(n);
        if (r >= nn) r = r - nn;
        if (r >= nn) r = r - nn;
        if (r >= nn) r = '0;
        return LW'(r);
    endfunction

    state_e                 state_q,     state_d;
    logic [LW-1:0]          idx_q,       idx_d;
    logic [LW-1:0]          n_q,         n_d;
    logic [LW-1:0]          pi_q,        pi_d;
    logic [LW-1:0]          g_q,         g_d;
    logic [LW-1:0]          f2x2_q,      f2x2_d;
    logic [MEM-1:0]         s1_q,        s1_d;
    logic [MEM-1:0]         s2_q,        s2_d;
    logic [FRAME_MAX-1:0]   buf_q,       buf_d;
    logic                   in_ready_q,  in_ready_d;
    logic                   busy_q,      busy_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_sys_q,   out_sys_d;
    logic                   out_par1_q,  out_par1_d;
    logic                   out_par2_q,  out_par2_d;
    logic                   out_tail_q,  out_tail_d;
    logic                   out_last_q,  out_last_d;
    logic [LW-1:0]          out_idx_q,   out_idx_d;

    logic                   accept;
    logic                   issue;
    logic                   to_idle;
    logic [LW-1:0]          cfg_n;
    logic [LW-1:0]          g_init;
    logic [LW-1:0]          f2x2_init;
    logic [LW-1:0]          n_last;
    logic [MEM:0]           enc1_data;
    logic [MEM:0]           enc2_data;
`ifdef TURBO_TERM_EN
    logic                   tail1_u;
    logic                   tail2_u;
    logic [MEM:0]           enc1_tail;
    logic [MEM:0]           enc2_tail;
`endif

    // Frame configuration decode and per-beat encoder arithmetic
    always_comb begin
        accept    = in_valid && in_ready_q;
        issue     = !out_valid_q || out_ready;
        cfg_n     = ((cfg_len == '0) || (cfg_len > NMAX)) ? NMAX : cfg_len;
        g_init    = mod_n((LW+2)'(cfg_f1) + (LW+2)'(cfg_f2), cfg_n);
        f2x2_init = mod_n((LW+2)'({cfg_f2, 1'b0}), cfg_n);
        n_last    = n_q - LW'(1);
        enc1_data = rsc_step(s1_q, buf_q[AW'(idx_q)]);
        enc2_data = rsc_step(s2_q, buf_q[AW'(pi_q)]);
`ifdef TURBO_TERM_EN
        tail1_u   = ^(s1_q & FB_POLY);
        tail2_u   = ^(s2_q & FB_POLY);
        enc1_tail = rsc_step(s1_q, tail1_u);
        enc2_tail = rsc_step(s2_q, tail2_u);
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        n_d         = n_q;
        pi_d        = pi_q;
        g_d         = g_q;
        f2x2_d      = f2x2_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        buf_d       = buf_q;
        out_valid_d = out_valid_q;
        out_sys_d   = out_sys_q;
        out_par1_d  = out_par1_q;
        out_par2_d  = out_par2_q;
        out_tail_d  = out_tail_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        to_idle     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    buf_d[0] = in_bit;
                    n_d      = cfg_n;
                    g_d      = g_init;
                    f2x2_d   = f2x2_init;
                    pi_d     = '0;
                    if (cfg_n == LW'(1)) begin
                        state_d = ENCODE;
                        idx_d   = '0;
                        s1_d    = '0;
                        s2_d    = '0;
                    end else begin
                        state_d = LOAD;
                        idx_d   = LW'(1);
                    end
                end
            end

            LOAD: begin
                if (accept) begin
                    buf_d[AW'(idx_q)] = in_bit;
                    if (idx_q == n_last) begin
                        state_d = ENCODE;
                        idx_d   = '0;
                        pi_d    = '0;
                        s1_d    = '0;
                        s2_d    = '0;
                    end else begin
                        idx_d = idx_q + LW'(1);
                    end
                end
            end

            ENCODE: begin
                if (out_valid_q && out_last_q) begin
                    to_idle = out_ready;
                end else if (issue) begin
                    out_valid_d = 1'b1;
                    out_sys_d   = buf_q[AW'(idx_q)];
                    out_par1_d  = enc1_data[MEM];
                    out_par2_d  = enc2_data[MEM];
                    out_tail_d  = 1'b0;
                    out_last_d  = 1'b0;
                    out_idx_d   = idx_q;
                    s1_d        = enc1_data[MEM-1:0];
                    s2_d        = enc2_data[MEM-1:0];
                    pi_d        = mod_n((LW+2)'(pi_q) + (LW+2)'(g_q), n_q);
                    g_d         = mod_n((LW+2)'(g_q) + (LW+2)'(f2x2_q), n_q);
                    if (idx_q == n_last) begin
`ifdef TURBO_TERM_EN
                        state_d = TERM1;
                        idx_d   = '0;
`else
                        out_last_d = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + LW'(1);
                    end
                end
            end

`ifdef TURBO_TERM_EN
            TERM1: begin
                if (issue) begin
                    out_valid_d = 1'b1;
                    out_sys_d   = tail1_u;
                    out_par1_d  = enc1_tail[MEM];
                    out_par2_d  = 1'b0;
                    out_tail_d  = 1'b1;
                    out_last_d  = 1'b0;
                    out_idx_d   = idx_q;
                    s1_d        = enc1_tail[MEM-1:0];
                    if (idx_q == TLAST) begin
                        state_d = TERM2;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + LW'(1);
                    end
                end
            end

            TERM2: begin
                if (out_valid_q && out_last_q) begin
                    to_idle = out_ready;
                end else if (issue) begin
                    out_valid_d = 1'b1;
                    out_sys_d   = tail2_u;
                    out_par1_d  = 1'b0;
                    out_par2_d  = enc2_tail[MEM];
                    out_tail_d  = 1'b1;
                    out_idx_d   = idx_q;
                    s2_d        = enc2_tail[MEM-1:0];
                    out_last_d  = (idx_q == TLAST);
                    if (idx_q != TLAST) begin
                        idx_d = idx_q + LW'(1);
                    end
                end
            end
`endif

            default: state_d = IDLE;
        endcase

        if (to_idle) begin
            state_d     = IDLE;
            idx_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_tail_d  = 1'b0;
        end

        in_ready_d = (state_d == IDLE) || (state_d == LOAD);
        busy_d     = (state_d != IDLE);
    end

    // Control, encoder and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            n_q         <= '0;
            pi_q        <= '0;
            g_q         <= '0;
            f2x2_q      <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sys_q   <= 1'b0;
            out_par1_q  <= 1'b0;
            out_par2_q  <= 1'b0;
            out_tail_q  <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            n_q         <= n_d;
            pi_q        <= pi_d;
            g_q         <= g_d;
            f2x2_q      <= f2x2_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_sys_q   <= out_sys_d;
            out_par1_q  <= out_par1_d;
            out_par2_q  <= out_par2_d;
            out_tail_q  <= out_tail_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
        end
    end

    // Frame buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_sys   = out_sys_q;
    assign out_par1  = out_par1_q;
    assign out_par2  = out_par2_q;
    assign out_tail  = out_tail_q;
    assign out_last  = out_last_q;
    assign out_idx   = out_idx_q;

endmodule

// File: doc/turbo_encoder_core.md
TURBO_ENCODER_CORE -- requirements
Module: turbo_encoder_core

Interface
REQ-001 SHALL have parameter MEM, default 2: RSC memory (state bits), legal 2..4.
REQ-002 SHALL have parameter FB_POLY, default 2'b11: feedback taps on state s[MEM-1:0].
REQ-003 SHALL have parameter FF_POLY, default 2'b10: feedforward taps on state.
REQ-004 SHALL have parameter FRAME_MAX, default 256: maximum frame length N; LW = $clog2(FRAME_MAX+1).
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1: in_bit valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts in_bit.
REQ-009 SHALL have port in_bit, input, 1: systematic data bit.
REQ-010 SHALL have ports cfg_len, cfg_f1 and cfg_f2, input, LW each: frame length N, QPP coefficients f1 and f2; sampled on the first accepted beat of a frame.
REQ-011 SHALL have port out_valid, output, 1: output beat valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts beat.
REQ-013 SHALL have ports out_sys, out_par1 and out_par2, output, 1 each: systematic bit, encoder-1 parity, encoder-2 parity.
REQ-014 SHALL have port out_tail, output, 1: beat is a termination beat.
REQ-015 SHALL have port out_last, output, 1: final beat of frame.
REQ-016 SHALL have port out_idx, output, LW: data index i, or tail step number.
REQ-017 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-018 RSC step SHALL be: a = u ^ ^(s & FB_POLY); p = a ^ ^(s & FF_POLY); s_next = {s[MEM-2:0], a}.
REQ-019 Effective N SHALL be FRAME_MAX when cfg_len is 0 or greater than FRAME_MAX; cfg_f1 and cfg_f2 SHALL be < N (precondition; violation gives an unspecified permutation but SHALL NOT hang).
REQ-020 FSM states SHALL be IDLE, LOAD, ENCODE, TERM1, TERM2; reset state is IDLE.
REQ-021 IDLE/LOAD: in_ready=1; each accepted bit SHALL be written to buffer[i]; IDLE SHALL go to LOAD on the first accepted bit; LOAD SHALL go to ENCODE after bit N-1 is accepted (N=1 goes IDLE to ENCODE directly).
REQ-022 in_ready SHALL be 0 in ENCODE, TERM1 and TERM2.
REQ-023 Interleaver SHALL compute incrementally: pi(0)=0, g(0)=(f1+f2) mod N, pi(i+1)=(pi+g) mod N, g(i+1)=(g+2*f2) mod N, using compare-subtract only (no divider).
REQ-024 ENCODE beat i SHALL give out_sys=buffer[i], out_par1 from encoder 1 with u=buffer[i], out_par2 from encoder 2 with u=buffer[pi(i)], out_idx=i.
REQ-025 Outputs SHALL be registered; the first ENCODE beat SHALL be valid the cycle after entering ENCODE.
REQ-026 A beat SHALL transfer when out_valid&&out_ready; while out_ready=0, all outputs and encoder states SHALL hold.
REQ-027 TERM1: MEM beats, u = ^(s1 & FB_POLY) so a=0; out_sys=u, out_par1=p, out_par2=0, out_tail=1, out_idx=0..MEM-1.
REQ-028 TERM2: same as TERM1 for encoder 2, with parity on out_par2 and out_par1=0.
REQ-029 Both encoder states SHALL be all-zero after TERM2; out_last SHALL be set on the final TERM2 beat, then go to IDLE.
REQ-030 Both encoder states SHALL clear to zero on entry to ENCODE.
REQ-031 The next frame's input SHALL be accepted in the cycle after the out_last transfer.

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, zero encoder states, indices and interleaver registers, and set out_valid, out_tail, out_last and busy to 0, out_idx to 0 and in_ready to 0.
REQ-033 in_ready SHALL go to 1 on the first clock edge after rst_n deasserts.
REQ-034 Reset mid-frame SHALL discard the partial frame; buffer contents need not clear.

Configuration
REQ-035 Macro TURBO_TERM_EN SHALL compile in TERM1/TERM2: with it defined, 2*MEM tail beats follow data; without it, ENCODE goes straight to IDLE, out_last is set on data beat N-1, out_tail is tied 0 and final states are not flushed.

Verification
REQ-036 Bench SHALL apply N=8, f1=3, f2=0 -> interleaved read order 0,3,6,1,4,7,2,5.
REQ-037 Bench SHALL apply N=4, f1=1, f2=0, input 1,0,0,0 -> out_par1 = 1,1,1,0; TERM1 sys=1,1, par1=0,1 (TERM_EN).
REQ-038 Bench SHALL apply an all-zero frame of N=256 -> every parity and tail bit 0; 256+4 beats; out_last on the final beat.
REQ-039 Bench SHALL hold out_ready=0 for 5 cycles mid-ENCODE -> outputs stable, no beat lost or duplicated.
REQ-040 Bench SHALL assert rst_n low at beat 3 of ENCODE -> IDLE, out_valid=0; a following frame encodes correctly.
REQ-041 Bench SHALL apply cfg_len=0 -> N=FRAME_MAX beats; a second back-to-back frame is accepted immediately after out_last.
